// File: rtl/util_fifo_rdpf_if.sv
// util_fifo_rdpf_if: bundles the controller/RAM read side and the output stream.
// Ports: EmptyN, Read, RData (toward the FIFO controller and its RAM);
//        ODat, OVld, ORdy, OCnt (toward the consumer).
interface util_fifo_rdpf_if #(
  parameter int DW = 32,
  parameter int CW = 2
);
  logic          EmptyN;
  logic          Read;
  logic [DW-1:0] RData;
  logic [DW-1:0] ODat;
  logic          OVld;
  logic          ORdy;
  logic [CW-1:0] OCnt;

  // master: the prefetch stage itself
  modport master (
    input  EmptyN, RData, ORdy,
    output Read, ODat, OVld, OCnt
  );

  // slave: the surrounding controller/RAM/sink environment
  modport slave (
    output EmptyN, RData, ORdy,
    input  Read, ODat, OVld, OCnt
  );
endinterface

// File: rtl/util_fifo_rdpf.sv
// util_fifo_rdpf: read-side prefetch turning FIFO EmptyN/Read + synchronous RAM data into a registered valid/ready stream.
// Latency: first word 2 cycles after EmptyN (3 with UTIL_FIFO_RDPF_RAMREG_EN); sustained 1 word/cycle.
// Backpressure: credit-based; Read only issues when buffered + in-flight words fit, so no RAM data is dropped.
// Ports: Clk, Rst (async, active-high); io.master carries EmptyN/Read/RData and ODat/OVld/ORdy/OCnt.
// Option: define UTIL_FIFO_RDPF_RAMREG_EN for a RAM with registered output (LAT=2, DEPTH=3).
module util_fifo_rdpf #(
  parameter int DW = 32,
  parameter int CW = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  util_fifo_rdpf_if.master io
);

`ifdef UTIL_FIFO_RDPF_RAMREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [DW-1:0] entry [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [LAT-1:0] inFl;     // one valid bit per outstanding RAM read
  logic [CW:0]   inFlCnt;
  logic [CW:0]   credit;
  logic [CW:0]   cntNext;
  logic          pop;
  logic          push;
  logic          rdEn;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inFlCnt = '0;
    for (int i = 0; i < LAT; i++) begin
      inFlCnt = inFlCnt + {{CW{1'b0}}, inFl[i]};
    end
    pop     = (cnt != '0) & io.ORdy;
    push    = inFl[LAT-1];
    // A word leaving this cycle frees its slot for a read issued this cycle,
    // which is what keeps the stream gap-free (ORdy -> Read is combinational).
    credit  = {1'b0, cnt} + inFlCnt - {{CW{1'b0}}, pop};
    rdEn    = io.EmptyN & ~Rst & (credit < DEPTH_C);
    cntNext = {1'b0, cnt} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  end

  assign io.Read = rdEn;
  assign io.OVld = (cnt != '0);
  assign io.ODat = entry[head];
  assign io.OCnt = cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      inFl <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      if (push) begin
        entry[tail] <= io.RData;
        tail        <= nextPtr(tail);
      end
      if (pop) begin
        head <= nextPtr(head);
      end
      cnt     <= cntNext[CW-1:0];
      inFl[0] <= rdEn;
      for (int i = 1; i < LAT; i++) begin
        inFl[i] <= inFl[i-1];
      end
    end
  end

`ifndef SYNTHESIS
  a_cntBound: assert property (@(posedge Clk) disable iff (Rst) cntNext <= DEPTH_C);
`endif

endmodule

// File: tb/tb_util_fifo_rdpf.sv
module tb_util_fifo_rdpf;
  localparam int DW = 32;
  localparam int CW = 2;
`ifdef UTIL_FIFO_RDPF_RAMREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;
  localparam int NRAND = 10000;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  util_fifo_rdpf_if #(.DW(DW), .CW(CW)) bus ();

  util_fifo_rdpf #(.DW(DW), .CW(CW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .io  (bus.master)
  );

  logic [31:0] src[$];   // words held by the upstream FIFO
  logic [31:0] expQ[$];  // scoreboard of words expected on ODat
  int nTests = 0, nFail = 0;
  int cyc = 0, beats = 0, firstRd = -1, firstVld = -1, lastPopCyc = 0;
  int readsSeen = 0, maxCnt = 0, holdErr = 0, loaded = 0, budget = 0;
  logic lastRd = 1'b0, gapOk = 1'b1, prevVld = 1'b0, prevRdy = 1'b0;
  logic [31:0] prevDat = '0, stage1 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.EmptyN = (src.size() != 0) && gapOk;
  endtask

  task automatic load(input logic [31:0] w);
    src.push_back(w);
    expQ.push_back(w);
  endtask

  // One clock: sample at negedge, model controller+RAM, drive after posedge.
  task automatic step();
    logic [31:0] w;
    logic rd;
    w = '0;
    @(negedge Clk);
    cyc++;
    rd = bus.Read;
    lastRd = rd;
    if (prevVld && !prevRdy && (!bus.OVld || bus.ODat !== prevDat)) holdErr++;
    if (int'(bus.OCnt) > maxCnt) maxCnt = int'(bus.OCnt);
    if (bus.OVld && firstVld < 0) firstVld = cyc;
    if (rd && firstRd < 0) firstRd = cyc;
    if (bus.OVld && bus.ORdy) begin
      if (expQ.size() == 0) check("spurious_beat", 32'd1, 32'd0);
      else check("beat_data", bus.ODat, expQ.pop_front());
      beats++;
      lastPopCyc = cyc;
    end
    prevVld = bus.OVld;
    prevRdy = bus.ORdy;
    prevDat = bus.ODat;
    if (rd) begin
      readsSeen++;
      if (!bus.EmptyN || src.size() == 0) check("read_without_emptyn", 32'd1, 32'd0);
      else w = src.pop_front();
    end
    @(posedge Clk);
    #1;
`ifdef UTIL_FIFO_RDPF_RAMREG_EN
    bus.RData = stage1;
    if (rd) stage1 = w;
`else
    if (rd) bus.RData = w;
`endif
    drive();
  endtask

  task automatic waitBeats(input string tag, input int target, input int maxCyc);
    int n;
    n = 0;
    while (beats < target && n < maxCyc) begin
      step();
      n++;
    end
    check(tag, beats, target);
  endtask

  initial begin
    Rst = 1'b1;
    bus.ORdy = 1'b0;
    bus.RData = '0;
    for (int i = 0; i < 16; i++) load(32'h10 + i);
    drive();
    #2;
    // reset state with EmptyN high
    check("rst_read", bus.Read, 0);
    check("rst_ovld", bus.OVld, 0);
    check("rst_ocnt", bus.OCnt, 0);
    check("rst_odat", bus.ODat, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    bus.ORdy = 1'b1;

    // streaming
    step();
    check("read_first_cycle", lastRd, 1);
    waitBeats("stream_beats", 16, 60);
    check("first_word_latency", firstVld - firstRd, LAT + 1);
    check("stream_no_gaps", lastPopCyc - firstVld, 15);

    // back-pressure
    for (int i = 0; i < 16; i++) load(32'h20 + i);
    drive();
    waitBeats("bp_first_beat", 17, 20);
    bus.ORdy = 1'b0;
    repeat (6) step();
    check("bp_ocnt_full", bus.OCnt, DEPTH);
    check("bp_read_low", bus.Read, 0);
    check("bp_odat_held", bus.ODat, 32'h21);
    check("bp_ovld_held", bus.OVld, 1);
    bus.ORdy = 1'b1;
    waitBeats("bp_drain_beats", 32, 80);
    check("bp_scoreboard_empty", expQ.size(), 0);

    // drain: single word, EmptyN falls while it is in flight
    readsSeen = 0;
    load(32'h30);
    drive();
    waitBeats("drain_beat", 33, 10);
    check("drain_single_read", readsSeen, 1);
    check("drain_ovld", bus.OVld, 0);
    check("drain_ocnt", bus.OCnt, 0);
    check("drain_read", bus.Read, 0);

    // mid-operation reset
    bus.ORdy = 1'b0;
    for (int i = 0; i < 8; i++) load(32'h40 + i);
    drive();
    repeat (8) step();
    check("mrst_ocnt_before", bus.OCnt, DEPTH);
    #2;
    Rst = 1'b1;
    #1;
    check("mrst_ovld", bus.OVld, 0);
    check("mrst_ocnt", bus.OCnt, 0);
    check("mrst_read", bus.Read, 0);
    src.delete();
    expQ.delete();
    stage1 = '0;
    prevVld = 1'b0;
    drive();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) load(32'h50 + i);
    bus.ORdy = 1'b1;
    drive();
    waitBeats("mrst_beats", beats + 4, 20);
    repeat (4) step();
    check("mrst_no_stale", expQ.size(), 0);

    // random traffic
    maxCnt = 0;
    holdErr = 0;
    loaded = 0;
    budget = 0;
    begin
      int target;
      target = beats + NRAND;
      while (beats < target && budget < 60000) begin
        while (src.size() < 4 && loaded < NRAND) begin
          load($urandom);
          loaded++;
        end
        gapOk = ($urandom_range(0, 3) != 0);
        bus.ORdy = $urandom_range(0, 1) == 1;
        drive();
        step();
        budget++;
      end
      check("rand_beats", beats, target);
    end
    check("rand_scoreboard_empty", expQ.size(), 0);
    check("rand_ocnt_le_depth", (maxCnt <= DEPTH), 1);
    check("odat_hold", holdErr, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
